// File: rtl/axi_llc_aw_line_splitter.sv
// Breaks each AW burst into descriptors that never cross a cache line and
// issues them one per cycle through a single registered output slot.
module axi_llc_aw_line_splitter #(
   parameter int unsigned AddrWidth         = 64,
   parameter int unsigned IdWidth           = 6,
   parameter int unsigned ByteOffsetLength  = 3,
   parameter int unsigned BlockOffsetLength = 3
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic [IdWidth-1:0]   aw_id_i,
   input  logic [AddrWidth-1:0] aw_addr_i,
   input  logic [7:0]           aw_len_i,
   input  logic [2:0]           aw_size_i,
   input  logic [1:0]           aw_burst_i,
   input  logic                 aw_valid_i,
   output logic                 aw_ready_o,
   output logic [IdWidth-1:0]   desc_id_o,
   output logic [AddrWidth-1:0] desc_addr_o,
   output logic [7:0]           desc_len_o,
   output logic [2:0]           desc_size_o,
   output logic [1:0]           desc_burst_o,
   output logic [1:0]           desc_resp_o,
   output logic                 desc_last_o,
   output logic                 desc_valid_o,
   input  logic                 desc_ready_i
);

   localparam int unsigned LineW = ByteOffsetLength + BlockOffsetLength;
   localparam logic [LineW:0] LineBytes = (LineW+1)'(1) << LineW;
   localparam logic [1:0] BurstFixed = 2'b00;
   localparam logic [1:0] RespOkay   = 2'b00;
   localparam logic [1:0] RespSlvErr = 2'b10;

   typedef enum logic {IDLE, SPLIT} state_e;

   state_e               state_q;
   logic [AddrWidth-1:0] addr_q;
   logic [8:0]           rem_q;

   logic                 can_load, aw_hs, aw_err;
   logic [AddrWidth-1:0] cur_addr, size_mask, next_addr;
   logic [2:0]           cur_size;
   logic [8:0]           cur_rem, to_end, chunk;
   logic [LineW:0]       off, span;

   // Chunk math is shared: IDLE works on the incoming AW, SPLIT on held state.
   // id/size/burst stay parked in the output register across a burst.
   always_comb begin
      can_load   = !desc_valid_o || desc_ready_i;
      aw_ready_o = (state_q == IDLE) && can_load;
      aw_hs      = aw_valid_i && aw_ready_o;
      aw_err     = aw_burst_i[1] || (aw_size_i > 3'(ByteOffsetLength));

      cur_addr   = (state_q == IDLE) ? aw_addr_i : addr_q;
      cur_size   = (state_q == IDLE) ? aw_size_i : desc_size_o;
      cur_rem    = (state_q == IDLE) ? ({1'b0, aw_len_i} + 9'd1) : rem_q;

      size_mask  = (AddrWidth'(1) << cur_size) - AddrWidth'(1);
      off        = {1'b0, cur_addr[LineW-1:0] & ~size_mask[LineW-1:0]};
      span       = LineBytes - off;
      to_end     = 9'(span >> cur_size);
      chunk      = (cur_rem < to_end) ? cur_rem : to_end;
      next_addr  = (cur_addr & ~size_mask) + (AddrWidth'(chunk) << cur_size);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= IDLE;
         addr_q       <= '0;
         rem_q        <= '0;
         desc_id_o    <= '0;
         desc_addr_o  <= '0;
         desc_len_o   <= '0;
         desc_size_o  <= '0;
         desc_burst_o <= '0;
         desc_resp_o  <= '0;
         desc_last_o  <= 1'b0;
         desc_valid_o <= 1'b0;
      end else begin
         if (desc_valid_o && desc_ready_i) desc_valid_o <= 1'b0;
         case (state_q)
            IDLE: begin
               if (aw_hs) begin
                  desc_valid_o <= 1'b1;
                  desc_id_o    <= aw_id_i;
                  desc_addr_o  <= aw_addr_i;
                  desc_size_o  <= aw_size_i;
                  desc_burst_o <= aw_burst_i;
                  if (aw_err || aw_burst_i == BurstFixed) begin
                     desc_len_o  <= aw_len_i;
                     desc_resp_o <= aw_err ? RespSlvErr : RespOkay;
                     desc_last_o <= 1'b1;
                  end else begin
                     desc_len_o  <= 8'(chunk - 9'd1);
                     desc_resp_o <= RespOkay;
                     desc_last_o <= (chunk == cur_rem);
                     if (chunk != cur_rem) begin
                        rem_q   <= cur_rem - chunk;
                        addr_q  <= next_addr;
                        state_q <= SPLIT;
                     end
                  end
               end
            end
            SPLIT: begin
               if (can_load) begin
                  desc_valid_o <= 1'b1;
                  desc_addr_o  <= addr_q;
                  desc_len_o   <= 8'(chunk - 9'd1);
                  desc_last_o  <= (chunk == cur_rem);
                  rem_q        <= cur_rem - chunk;
                  addr_q       <= next_addr;
                  if (chunk == cur_rem) state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axi_llc_aw_line_splitter.sv
// Directed bench for the AW line splitter: hand-computed descriptor streams,
// error bursts, backpressure and reset during a split.
module tb_axi_llc_aw_line_splitter;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic [5:0]  aw_id_i;
   logic [63:0] aw_addr_i;
   logic [7:0]  aw_len_i;
   logic [2:0]  aw_size_i;
   logic [1:0]  aw_burst_i;
   logic        aw_valid_i;
   logic        aw_ready_o;
   logic [5:0]  desc_id_o;
   logic [63:0] desc_addr_o;
   logic [7:0]  desc_len_o;
   logic [2:0]  desc_size_o;
   logic [1:0]  desc_burst_o;
   logic [1:0]  desc_resp_o;
   logic        desc_last_o;
   logic        desc_valid_o;
   logic        desc_ready_i;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk_i = ~clk_i;

   axi_llc_aw_line_splitter dut (
      .clk_i, .rst_i,
      .aw_id_i, .aw_addr_i, .aw_len_i, .aw_size_i, .aw_burst_i,
      .aw_valid_i, .aw_ready_o,
      .desc_id_o, .desc_addr_o, .desc_len_o, .desc_size_o, .desc_burst_o,
      .desc_resp_o, .desc_last_o, .desc_valid_o, .desc_ready_i
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance past the next rising edge; outputs are sampled 1 ns after it.
   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic chk_desc(input string tag, input logic [63:0] addr, input logic [7:0] len,
                           input logic last, input logic [1:0] resp, input logic [5:0] id);
      chk({tag, ".valid"}, 64'(desc_valid_o), 64'd1);
      chk({tag, ".addr"},  desc_addr_o, addr);
      chk({tag, ".len"},   64'(desc_len_o), 64'(len));
      chk({tag, ".last"},  64'(desc_last_o), 64'(last));
      chk({tag, ".resp"},  64'(desc_resp_o), 64'(resp));
      chk({tag, ".id"},    64'(desc_id_o), 64'(id));
   endtask

   // Present one AW for a single edge; aw_ready_o must be high when offered.
   task automatic send_aw(input string tag, input logic [5:0] id, input logic [63:0] addr,
                          input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
      aw_id_i = id; aw_addr_i = addr; aw_len_i = len; aw_size_i = size; aw_burst_i = burst;
      aw_valid_i = 1'b1;
      #1;
      chk({tag, ".aw_ready"}, 64'(aw_ready_o), 64'd1);
      step();
      aw_valid_i = 1'b0;
   endtask

   initial begin
      rst_i = 1'b1; aw_valid_i = 1'b0; desc_ready_i = 1'b1;
      aw_id_i = '0; aw_addr_i = '0; aw_len_i = '0; aw_size_i = '0; aw_burst_i = '0;
      step(); step();
      rst_i = 1'b0;
      #1;
      chk("rst.valid", 64'(desc_valid_o), 64'd0);
      chk("rst.addr",  desc_addr_o, 64'd0);
      chk("rst.len",   64'(desc_len_o), 64'd0);
      chk("rst.last",  64'(desc_last_o), 64'd0);
      chk("rst.aw_ready", 64'(aw_ready_o), 64'd1);

      // Aligned full-line burst: single descriptor next cycle.
      send_aw("a", 6'd1, 64'h100, 8'd7, 3'd3, 2'b01);
      chk_desc("a0", 64'h100, 8'd7, 1'b1, 2'b00, 6'd1);
      chk("a0.size",  64'(desc_size_o), 64'd3);
      chk("a0.burst", 64'(desc_burst_o), 64'd1);
      step();
      chk("a.idle", 64'(desc_valid_o), 64'd0);

      // Crosses a line at 0x140.
      send_aw("b", 6'd2, 64'h130, 8'd7, 3'd3, 2'b01);
      chk_desc("b0", 64'h130, 8'd1, 1'b0, 2'b00, 6'd2);
      chk("b0.aw_ready", 64'(aw_ready_o), 64'd0);
      step();
      chk_desc("b1", 64'h140, 8'd5, 1'b1, 2'b00, 6'd2);
      step();
      chk("b.idle", 64'(desc_valid_o), 64'd0);

      // Word-size beats, one beat left before the boundary.
      send_aw("c", 6'd3, 64'h13C, 8'd3, 3'd2, 2'b01);
      chk_desc("c0", 64'h13C, 8'd0, 1'b0, 2'b00, 6'd3);
      step();
      chk_desc("c1", 64'h140, 8'd2, 1'b1, 2'b00, 6'd3);
      chk("c1.size", 64'(desc_size_o), 64'd2);
      step();

      // 256-beat burst: 32 line chunks, then a second AW accepted on the last.
      send_aw("d", 6'd4, 64'h0, 8'd255, 3'd3, 2'b01);
      for (int k = 0; k < 32; k++) begin
         chk_desc($sformatf("d%0d", k), 64'(k * 64), 8'd7, (k == 31), 2'b00, 6'd4);
         if (k < 31) begin
            chk($sformatf("d%0d.aw_ready", k), 64'(aw_ready_o), 64'd0);
            step();
         end
      end
      send_aw("d2", 6'd5, 64'h100, 8'd7, 3'd3, 2'b01);
      chk_desc("d2", 64'h100, 8'd7, 1'b1, 2'b00, 6'd5);
      step();

      // Error and fixed bursts: one descriptor each, no splitting.
      send_aw("e", 6'd6, 64'h13C, 8'd3, 3'd3, 2'b10);
      chk_desc("e_wrap", 64'h13C, 8'd3, 1'b1, 2'b10, 6'd6);
      step();
      send_aw("f", 6'd7, 64'h130, 8'd2, 3'd4, 2'b01);
      chk_desc("f_size", 64'h130, 8'd2, 1'b1, 2'b10, 6'd7);
      step();
      send_aw("g", 6'd8, 64'h130, 8'd7, 3'd3, 2'b11);
      chk_desc("g_rsvd", 64'h130, 8'd7, 1'b1, 2'b10, 6'd8);
      step();
      send_aw("h", 6'd9, 64'h130, 8'd7, 3'd3, 2'b00);
      chk_desc("h_fixed", 64'h130, 8'd7, 1'b1, 2'b00, 6'd9);
      step();

      // Backpressure: first chunk held stable.
      desc_ready_i = 1'b0;
      send_aw("p", 6'd10, 64'h130, 8'd7, 3'd3, 2'b01);
      for (int k = 0; k < 5; k++) begin
         chk_desc($sformatf("p_hold%0d", k), 64'h130, 8'd1, 1'b0, 2'b00, 6'd10);
         chk($sformatf("p_hold%0d.aw_ready", k), 64'(aw_ready_o), 64'd0);
         step();
      end
      desc_ready_i = 1'b1;
      #1;
      chk_desc("p0", 64'h130, 8'd1, 1'b0, 2'b00, 6'd10);
      step();
      chk_desc("p1", 64'h140, 8'd5, 1'b1, 2'b00, 6'd10);
      step();

      // Reset mid-split drops the pending and unsent chunks.
      desc_ready_i = 1'b0;
      send_aw("r", 6'd11, 64'h130, 8'd7, 3'd3, 2'b01);
      chk_desc("r0", 64'h130, 8'd1, 1'b0, 2'b00, 6'd11);
      rst_i = 1'b1;
      step();
      rst_i = 1'b0;
      #1;
      chk("r.valid", 64'(desc_valid_o), 64'd0);
      chk("r.aw_ready", 64'(aw_ready_o), 64'd1);
      desc_ready_i = 1'b1;
      for (int k = 0; k < 5; k++) begin
         step();
         chk($sformatf("r.quiet%0d", k), 64'(desc_valid_o), 64'd0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
